// File: rtl/sodor_mem_pipe_model_if.sv
// Core-to-memory bus for the Sodor memory model: combinational instruction
// fetch port plus a valid/ready data request/response port.
interface sodor_mem_pipe_model_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [DATA_W-1:0] dmem_req_data;
  logic              dmem_req_write_en;
  logic [2:0]        dmem_req_typ;

  logic              dmem_resp_valid;
  logic              dmem_resp_ready;
  logic [DATA_W-1:0] dmem_resp_data;

  modport master (
    output imem_addr,
    input  imem_data,
    output dmem_req_valid,
    input  dmem_req_ready,
    output dmem_req_addr,
    output dmem_req_data,
    output dmem_req_write_en,
    output dmem_req_typ,
    input  dmem_resp_valid,
    output dmem_resp_ready,
    input  dmem_resp_data
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  dmem_req_valid,
    output dmem_req_ready,
    input  dmem_req_addr,
    input  dmem_req_data,
    input  dmem_req_write_en,
    input  dmem_req_typ,
    output dmem_resp_valid,
    input  dmem_resp_ready,
    output dmem_resp_data
  );
endinterface

// File: rtl/sodor_mem_pipe_model.sv
// Sodor memory model: async-read instruction port, data port with fixed-latency
// delay pipeline feeding an in-order response FIFO, bounded outstanding count.
module sodor_mem_pipe_model #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned DMEM_LAT = 2,
  parameter int unsigned MAX_OUT  = 4
) (
  input logic                  clk,
  input logic                  rst,
  sodor_mem_pipe_model_if.slave bus
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    TYP_B  = 3'd1,
    TYP_H  = 3'd2,
    TYP_W  = 3'd3,
    TYP_BU = 3'd4,
    TYP_HU = 3'd5
  } typ_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [IW-1:0]     i_idx, d_idx;
  logic [1:0]        lane;
  logic              unused_bits;

  assign i_addr      = bus.imem_addr;
  assign d_addr      = bus.dmem_req_addr;
  assign i_idx       = i_addr[IW+1:2];
  assign d_idx       = d_addr[IW+1:2];
  assign lane        = d_addr[1:0];
  assign unused_bits = ^{i_addr, d_addr};

  assign bus.imem_data = mem[i_idx];

  logic              accept, resp_fire;
  logic [CW-1:0]     outstanding, fifo_cnt;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [DATA_W-1:0] fifo [MAX_OUT];

  assign bus.dmem_req_ready  = (outstanding < CW'(MAX_OUT));
  assign accept              = bus.dmem_req_valid && bus.dmem_req_ready;
  assign bus.dmem_resp_valid = (fifo_cnt != '0);
  assign bus.dmem_resp_data  = bus.dmem_resp_valid ? fifo[rd_ptr] : '0;
  assign resp_fire           = bus.dmem_resp_valid && bus.dmem_resp_ready;

  // Load extraction and store lane steering for the current request
  logic [DATA_W-1:0] rword, ld_data, st_data, entry_data;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [3:0]        st_be;

  always_comb begin
    rword   = mem[d_idx];
    rbyte   = rword[{lane, 3'b000} +: 8];
    rhalf   = lane[1] ? rword[31:16] : rword[15:0];
    ld_data = rword;
    st_be   = 4'b1111;
    st_data = bus.dmem_req_data;
    case (bus.dmem_req_typ)
      TYP_B: begin
        ld_data = {{24{rbyte[7]}}, rbyte};
        st_be   = 4'b0001 << lane;
        st_data = {4{bus.dmem_req_data[7:0]}};
      end
      TYP_BU: begin
        ld_data = {24'h0, rbyte};
        st_be   = 4'b0001 << lane;
        st_data = {4{bus.dmem_req_data[7:0]}};
      end
      TYP_H: begin
        ld_data = {{16{rhalf[15]}}, rhalf};
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.dmem_req_data[15:0]}};
      end
      TYP_HU: begin
        ld_data = {16'h0, rhalf};
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.dmem_req_data[15:0]}};
      end
      default: begin
        ld_data = rword;
        st_be   = 4'b1111;
        st_data = bus.dmem_req_data;
      end
    endcase
    entry_data = bus.dmem_req_write_en ? '0 : ld_data;
  end

  // Memory is never reset; writes are suppressed while rst is held low
  always_ff @(posedge clk) begin
    if (rst && accept && bus.dmem_req_write_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (st_be[b]) mem[d_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // LAT-1 register stages; with LAT=1 an accepted request lands in the FIFO directly
  logic              exit_valid;
  logic [DATA_W-1:0] exit_data;

  if (DMEM_LAT == 1) begin : g_direct
    assign exit_valid = accept;
    assign exit_data  = entry_data;
  end else begin : g_pipe
    logic              pv [DMEM_LAT-1];
    logic [DATA_W-1:0] pd [DMEM_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned s = 0; s < DMEM_LAT - 1; s++) begin
          pv[s] <= 1'b0;
          pd[s] <= '0;
        end
      end else begin
        pv[0] <= accept;
        pd[0] <= entry_data;
        for (int unsigned s = 1; s < DMEM_LAT - 1; s++) begin
          pv[s] <= pv[s-1];
          pd[s] <= pd[s-1];
        end
      end
    end

    assign exit_valid = pv[DMEM_LAT-2];
    assign exit_data  = pd[DMEM_LAT-2];
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (exit_valid) fifo[wr_ptr] <= exit_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (exit_valid) wr_ptr <= next_ptr(wr_ptr);
      if (resp_fire)  rd_ptr <= next_ptr(rd_ptr);
      case ({exit_valid, resp_fire})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
      case ({accept, resp_fire})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !((fifo_cnt == CW'(MAX_OUT)) && exit_valid && !resp_fire));

endmodule

// File: tb/tb_sodor_mem_pipe_model.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_sodor_mem_pipe_model;
  localparam int unsigned DEPTH   = 4096;
  localparam int unsigned LAT     = 2;
  localparam int unsigned MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sodor_mem_pipe_model_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  sodor_mem_pipe_model #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .DMEM_LAT(LAT), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned edge_no = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] mmem [int unsigned];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] ln,
                                         input logic [2:0] t);
    logic [31:0] b, h;
    b = (w >> (8 * ln)) & 32'hFF;
    h = (w >> (16 * ln[1])) & 32'hFFFF;
    case (t)
      3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d,
                                           input logic [1:0] ln, input logic [2:0] t);
    logic [31:0] m, ds;
    case (t)
      3'd1, 3'd4: begin m = 32'hFF << (8 * ln);     ds = (d & 32'hFF) << (8 * ln); end
      3'd2, 3'd5: begin m = 32'hFFFF << (16 * ln[1]); ds = (d & 32'hFFFF) << (16 * ln[1]); end
      default:    begin m = 32'hFFFF_FFFF;          ds = d; end
    endcase
    return (w & ~m) | (ds & m);
  endfunction

  // One cycle: drive just after a rising edge, check at the falling edge,
  // advance the model for the coming edge, then move past that edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic we, input logic [2:0] t, input logic rr,
                      input logic [31:0] ia,
                      output logic o_ready, output logic o_rv, output logic [31:0] o_rd,
                      output logic [31:0] o_imem, output logic o_acc);
    logic        e_ready, e_rv;
    logic [31:0] w;
    int unsigned wi;
    exp_t        e;
    bus.dmem_req_valid    = v;
    bus.dmem_req_addr     = a;
    bus.dmem_req_data     = d;
    bus.dmem_req_write_en = we;
    bus.dmem_req_typ      = t;
    bus.dmem_resp_ready   = rr;
    bus.imem_addr         = ia;
    @(negedge clk);
    o_ready = bus.dmem_req_ready;
    o_rv    = bus.dmem_resp_valid;
    o_rd    = bus.dmem_resp_data;
    o_imem  = bus.imem_data;
    e_ready = (mq.size() < MAX_OUT);
    e_rv    = (mq.size() > 0) && (mq[0].due <= edge_no);
    chk("req_ready", 32'(o_ready), 32'(e_ready));
    chk("resp_valid", 32'(o_rv), 32'(e_rv));
    if (e_rv) chk("resp_data", o_rd, mq[0].data);
    wi = (ia >> 2) % DEPTH;
    if (mmem.exists(wi)) chk("imem_data", o_imem, mmem[wi]);
    o_acc = v && e_ready;
    if (e_rv && rr) void'(mq.pop_front());
    if (o_acc) begin
      wi = (a >> 2) % DEPTH;
      w  = mmem.exists(wi) ? mmem[wi] : 32'h0;
      e.due = edge_no + LAT;
      if (we) begin
        mmem[wi] = st_merge(w, d, a[1:0], t);
        e.data   = 32'h0;
      end else begin
        e.data = ld_ext(w, a[1:0], t);
      end
      mq.push_back(e);
    end
    @(posedge clk);
    edge_no++;
    #1;
  endtask

  task automatic go(input logic v, input logic [31:0] a, input logic [31:0] d,
                    input logic we, input logic [2:0] t, input logic rr);
    logic r, rv, ac;
    logic [31:0] rd, im;
    step(v, a, d, we, t, rr, 32'h0, r, rv, rd, im, ac);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic [2:0]  t;
    logic [31:0] ia;
    logic        ci;
    logic [31:0] x_im;
    logic        x_rv;
    logic [31:0] x_rd;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic we, input logic [2:0] t, input logic [31:0] ia,
                              input logic ci, input logic [31:0] x_im,
                              input logic x_rv, input logic [31:0] x_rd);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.we = we; r.t = t; r.ia = ia;
    r.ci = ci; r.x_im = x_im; r.x_rv = x_rv; r.x_rd = x_rd;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic        o_ready, o_rv, o_acc;
    logic [31:0] o_rd, o_imem;
    int unsigned acc_n, idx, nxt, guard;

    // Latency/extension, byte store, wrap and same-cycle fetch (resp_ready = 1)
    tbl.push_back(mk(1, 32'h40,   32'h8000_80F1, 1, 3, 32'h0,  0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(1, 32'h40,   32'h0,         0, 3, 32'h0,  0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(1, 32'h40,   32'h0,         0, 1, 32'h0,  0, 32'h0,         1, 32'h0));
    tbl.push_back(mk(1, 32'h40,   32'h0,         0, 4, 32'h0,  0, 32'h0,         1, 32'h8000_80F1));
    tbl.push_back(mk(1, 32'h40,   32'h0,         0, 2, 32'h0,  0, 32'h0,         1, 32'hFFFF_FFF1));
    tbl.push_back(mk(1, 32'h40,   32'h0,         0, 5, 32'h0,  0, 32'h0,         1, 32'h0000_00F1));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h0,  0, 32'h0,         1, 32'hFFFF_80F1));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h0,  0, 32'h0,         1, 32'h0000_80F1));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h0,  0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(1, 32'h40,   32'hFFFF_FFFF, 1, 3, 32'h40, 1, 32'h8000_80F1, 0, 32'h0));
    tbl.push_back(mk(1, 32'h42,   32'h0000_0012, 1, 1, 32'h40, 1, 32'hFFFF_FFFF, 0, 32'h0));
    tbl.push_back(mk(1, 32'h40,   32'h0,         0, 3, 32'h0,  0, 32'h0,         1, 32'h0));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h0,  0, 32'h0,         1, 32'h0));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h40, 1, 32'hFF12_FFFF, 1, 32'hFF12_FFFF));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h0,  0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(1, 32'h4000, 32'hDEAD_BEEF, 1, 3, 32'h0,  0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(1, 32'h0,    32'h0,         0, 3, 32'h0,  1, 32'hDEAD_BEEF, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h0,  0, 32'h0,         1, 32'h0));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h0,  0, 32'h0,         1, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 32'h0,    32'h0,         0, 3, 32'h0,  0, 32'h0,         0, 32'h0));

    bus.imem_addr = '0; bus.dmem_req_valid = 1'b0; bus.dmem_req_addr = '0;
    bus.dmem_req_data = '0; bus.dmem_req_write_en = 1'b0; bus.dmem_req_typ = 3'd3;
    bus.dmem_resp_ready = 1'b0;

    // Reset state, then release between edges and use the very next edge
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req_ready", 32'(bus.dmem_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.dmem_resp_valid), 32'd0);
    chk("rst_resp_data", bus.dmem_resp_data, 32'h0);
    rst = 1'b1;
    edge_no = 0;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].t, 1'b1, tbl[i].ia,
           o_ready, o_rv, o_rd, o_imem, o_acc);
      chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'd1);
      chk($sformatf("tbl%0d_rv", i), 32'(o_rv), 32'(tbl[i].x_rv));
      if (tbl[i].x_rv) chk($sformatf("tbl%0d_rd", i), o_rd, tbl[i].x_rd);
      if (tbl[i].ci) chk($sformatf("tbl%0d_imem", i), o_imem, tbl[i].x_im);
    end

    // Backpressure: preload five distinct words, then hold resp_ready low
    for (int unsigned i = 0; i < 5; i++) go(1, 32'h100 + 4 * i, 32'hA000_0000 + i, 1, 3, 1);
    for (int unsigned i = 0; i < 4; i++) go(0, 32'h0, 32'h0, 0, 3, 1);
    acc_n = 0; idx = 0;
    for (int unsigned c = 0; c < 8; c++) begin
      step(1, 32'h100 + 4 * idx, 32'h0, 0, 3, 0, 32'h100, o_ready, o_rv, o_rd, o_imem, o_acc);
      if (o_acc) begin acc_n++; idx++; end
    end
    chk("bp_accepted", acc_n, 32'd4);
    chk("bp_ready_low", 32'(o_ready), 32'd0);
    step(1, 32'h100 + 4 * idx, 32'h0, 0, 3, 1, 32'h100, o_ready, o_rv, o_rd, o_imem, o_acc);
    chk("bp_head_data", o_rd, 32'hA000_0000);
    chk("bp_ready_still_low", 32'(o_ready), 32'd0);
    step(1, 32'h100 + 4 * idx, 32'h0, 0, 3, 0, 32'h100, o_ready, o_rv, o_rd, o_imem, o_acc);
    chk("bp_ready_after_pop", 32'(o_ready), 32'd1);
    nxt = 1; guard = 0;
    while (nxt < 5 && guard < 20) begin
      step(0, 32'h0, 32'h0, 0, 3, 1, 32'h100, o_ready, o_rv, o_rd, o_imem, o_acc);
      if (o_rv) begin
        chk("bp_order", o_rd, 32'hA000_0000 + nxt);
        nxt++;
      end
      guard++;
    end
    chk("bp_drained", nxt, 32'd5);

    // Reset mid-flight: three loads outstanding, pulse rst low between edges
    for (int unsigned i = 0; i < 3; i++) go(1, 32'h100 + 4 * i, 32'h0, 0, 3, 0);
    go(0, 32'h0, 32'h0, 0, 3, 0);
    bus.dmem_req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(bus.dmem_resp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.dmem_req_ready), 32'd1);
    chk("mid_rst_resp_data", bus.dmem_resp_data, 32'h0);
    #1 rst = 1'b1;
    mq.delete();
    @(posedge clk); edge_no++; #1;
    step(1, 32'h104, 32'h0, 0, 3, 1, 32'h104, o_ready, o_rv, o_rd, o_imem, o_acc);
    chk("post_rst_no_stale", 32'(o_rv), 32'd0);
    step(0, 32'h0, 32'h0, 0, 3, 1, 32'h104, o_ready, o_rv, o_rd, o_imem, o_acc);
    chk("post_rst_no_stale2", 32'(o_rv), 32'd0);
    step(0, 32'h0, 32'h0, 0, 3, 1, 32'h104, o_ready, o_rv, o_rd, o_imem, o_acc);
    chk("post_rst_data", o_rd, 32'hA000_0001);

    // Randomized traffic over a 16-word region, with address aliasing past DEPTH
    for (int unsigned i = 0; i < 16; i++) go(1, 32'h800 + 4 * i, $urandom, 1, 3, 1);
    for (int unsigned n = 0; n < 400; n++) begin
      logic [31:0] a, ia;
      a  = 32'h800 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a + 32'h4000;
      ia = 32'h800 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      step($urandom_range(0, 9) < 7, a, $urandom, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 6, ia,
           o_ready, o_rv, o_rd, o_imem, o_acc);
    end
    guard = 0;
    while (mq.size() > 0 && guard < 64) begin
      go(0, 32'h0, 32'h0, 0, 3, 1);
      guard++;
    end
    chk("final_drain", mq.size(), 32'd0);
    step(0, 32'h0, 32'h0, 0, 3, 1, 32'h0, o_ready, o_rv, o_rd, o_imem, o_acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
